// File: rtl/vga_timing_gen.sv
// Raster timing source: free-running pixel/line counters plus zero-latency decode
// of sync, blanking, line and frame strobes from the current counter values.
module vga_timing_gen #(
  parameter int H_ACTIVE        = 640,
  parameter int H_FRONT         = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BACK          = 48,
  parameter int V_ACTIVE        = 480,
  parameter int V_FRONT         = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BACK          = 33,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic       line_start,
  output logic       next_frame,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic       SYNC_ASSERT = ~SYNC_ACTIVE_LOW;

  logic x_last;
  logic y_last;
  logic in_hsync;
  logic in_vsync;

  assign x_last = (x == H_LAST);
  assign y_last = (y == V_LAST);

  // frame_count advances on the same edge that wraps both counters,
  // so the new count appears together with x=0, y=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      x           <= '0;
      y           <= '0;
      frame_count <= '0;
    end else if (x_last) begin
      x <= '0;
      if (y_last) begin
        y           <= '0;
        frame_count <= frame_count + 8'd1;
      end else begin
        y <= y + 10'd1;
      end
    end else begin
      x <= x + 10'd1;
    end
  end

  // Pure decode of the registered counters: RGB derived from x/y lines up with these.
  always_comb begin
    in_hsync   = (x >= HS_START) && (x < HS_END);
    in_vsync   = (y >= VS_START) && (y < VS_END);
    hsync      = in_hsync ? SYNC_ASSERT : ~SYNC_ASSERT;
    vsync      = in_vsync ? SYNC_ASSERT : ~SYNC_ASSERT;
    display_on = (x < H_VIS) && (y < V_VIS);
    line_start = (x == 10'd0);
    next_frame = (x == 10'd0) && (y == V_VIS);
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 geometry against a vector table,
// and a tiny active-high geometry against a per-cycle scoreboard for frame-level behaviour.
module tb_vga_timing_gen;

  logic       clk;
  logic       rst_a;
  logic       rst_s;

  logic [9:0] x_a, y_a;
  logic       hs_a, vs_a, de_a, ls_a, nf_a;
  logic [7:0] fc_a;

  logic [9:0] x_s, y_s;
  logic       hs_s, vs_s, de_s, ls_s, nf_s;
  logic [7:0] fc_s;

  int checks = 0;
  int errors = 0;

  vga_timing_gen dut_a (
    .clk(clk), .rst(rst_a), .x(x_a), .y(y_a), .hsync(hs_a), .vsync(vs_a),
    .display_on(de_a), .line_start(ls_a), .next_frame(nf_a), .frame_count(fc_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .SYNC_ACTIVE_LOW(1'b0)
  ) dut_s (
    .clk(clk), .rst(rst_s), .x(x_s), .y(y_s), .hsync(hs_s), .vsync(vs_s),
    .display_on(de_s), .line_start(ls_s), .next_frame(nf_s), .frame_count(fc_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int cyc; int x; int y; bit hs; bit vs; bit de; bit ls; bit nf;
  } vec_t;

  typedef struct {
    int x; int y; bit hs; bit vs; bit de; bit ls; bit nf; int fc;
  } exp_t;

  exp_t sb[$];
  int   mx, my, mfc;
  int   vs_cnt, hs_cnt, ls_cnt, de_cnt, nf_cnt, nf_x, nf_y, max_x, max_y;

  // Small geometry: H 8/2/2/2 (total 14), V 4/1/1/1 (total 7), sync active high.
  task automatic s_cycle(input bit r);
    exp_t e;
    @(negedge clk);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("s_x", int'(x_s), e.x);
      chk("s_y", int'(y_s), e.y);
      chk("s_hsync", int'(hs_s), int'(e.hs));
      chk("s_vsync", int'(vs_s), int'(e.vs));
      chk("s_display_on", int'(de_s), int'(e.de));
      chk("s_line_start", int'(ls_s), int'(e.ls));
      chk("s_next_frame", int'(nf_s), int'(e.nf));
      chk("s_frame_count", int'(fc_s), e.fc);
    end
    if (vs_s) vs_cnt++;
    if (hs_s) hs_cnt++;
    if (ls_s) ls_cnt++;
    if (de_s) de_cnt++;
    if (nf_s) begin nf_cnt++; nf_x = int'(x_s); nf_y = int'(y_s); end
    if (int'(x_s) > max_x) max_x = int'(x_s);
    if (int'(y_s) > max_y) max_y = int'(y_s);
    rst_s = r;
    if (r) begin
      mx = 0; my = 0; mfc = 0;
    end else if (mx == 13) begin
      mx = 0;
      if (my == 6) begin my = 0; mfc = (mfc + 1) % 256; end
      else my++;
    end else begin
      mx++;
    end
    e.x  = mx;
    e.y  = my;
    e.hs = (mx == 10 || mx == 11);
    e.vs = (my == 5);
    e.de = (mx < 8) && (my < 4);
    e.ls = (mx == 0);
    e.nf = (mx == 0) && (my == 4);
    e.fc = mfc;
    sb.push_back(e);
  endtask

  task automatic clear_counts();
    vs_cnt = 0; hs_cnt = 0; ls_cnt = 0; de_cnt = 0; nf_cnt = 0;
    nf_x = -1; nf_y = -1; max_x = 0; max_y = 0;
  endtask

  initial begin
    vec_t tbl[12];
    int   idx;
    int   hs_low, ls_n;
    int   prev_fc, n;
    bit   wrap_seen, found;

    tbl[0]  = '{0,    0,   0, 1, 1, 1, 1, 0};
    tbl[1]  = '{639,  639, 0, 1, 1, 1, 0, 0};
    tbl[2]  = '{640,  640, 0, 1, 1, 0, 0, 0};
    tbl[3]  = '{655,  655, 0, 1, 1, 0, 0, 0};
    tbl[4]  = '{656,  656, 0, 0, 1, 0, 0, 0};
    tbl[5]  = '{751,  751, 0, 0, 1, 0, 0, 0};
    tbl[6]  = '{752,  752, 0, 1, 1, 0, 0, 0};
    tbl[7]  = '{799,  799, 0, 1, 1, 0, 0, 0};
    tbl[8]  = '{800,  0,   1, 1, 1, 1, 1, 0};
    tbl[9]  = '{1439, 639, 1, 1, 1, 1, 0, 0};
    tbl[10] = '{1440, 640, 1, 1, 1, 0, 0, 0};
    tbl[11] = '{1551, 751, 1, 0, 1, 0, 0, 0};

    rst_a = 1'b1;
    rst_s = 1'b1;
    mx = 0; my = 0; mfc = 0;
    clear_counts();

    // Default geometry: get to x=700, y=1, then a 3-cycle reset from there.
    @(negedge clk);
    @(negedge clk);
    rst_a = 1'b0;
    repeat (1500) @(negedge clk);
    chk("a_pre_x", int'(x_a), 700);
    chk("a_pre_y", int'(y_a), 1);
    rst_a = 1'b1;
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    chk("a_rst_frame_count", int'(fc_a), 0);

    idx = 0; hs_low = 0; ls_n = 0;
    for (int k = 0; k < 1600; k++) begin
      if (k > 0) @(negedge clk);
      if (k < 800 && !hs_a) hs_low++;
      if (ls_a) ls_n++;
      if (idx < 12 && tbl[idx].cyc == k) begin
        chk($sformatf("a_x@%0d", k), int'(x_a), tbl[idx].x);
        chk($sformatf("a_y@%0d", k), int'(y_a), tbl[idx].y);
        chk($sformatf("a_hsync@%0d", k), int'(hs_a), int'(tbl[idx].hs));
        chk($sformatf("a_vsync@%0d", k), int'(vs_a), int'(tbl[idx].vs));
        chk($sformatf("a_display_on@%0d", k), int'(de_a), int'(tbl[idx].de));
        chk($sformatf("a_line_start@%0d", k), int'(ls_a), int'(tbl[idx].ls));
        chk($sformatf("a_next_frame@%0d", k), int'(nf_a), int'(tbl[idx].nf));
        idx++;
      end
    end
    chk("a_table_done", idx, 12);
    chk("a_hsync_low_cycles", hs_low, 96);
    chk("a_line_starts", ls_n, 2);

    // Small geometry: one full frame from reset.
    s_cycle(1'b1);
    s_cycle(1'b1);
    clear_counts();
    repeat (98) s_cycle(1'b0);
    chk("s_vsync_cycles", vs_cnt, 14);
    chk("s_hsync_cycles", hs_cnt, 14);
    chk("s_line_starts", ls_cnt, 7);
    chk("s_display_cycles", de_cnt, 32);
    chk("s_next_frame_count", nf_cnt, 1);
    chk("s_next_frame_x", nf_x, 0);
    chk("s_next_frame_y", nf_y, 4);
    chk("s_max_x", max_x, 13);
    chk("s_max_y", max_y, 6);
    s_cycle(1'b0);
    chk("s_eof_x", int'(x_s), 0);
    chk("s_eof_y", int'(y_s), 0);
    chk("s_eof_frame_count", int'(fc_s), 1);

    // 256 frames: frame_count passes 255->0 and returns to 1.
    clear_counts();
    wrap_seen = 1'b0;
    prev_fc = int'(fc_s);
    for (int k = 0; k < 256 * 98; k++) begin
      s_cycle(1'b0);
      if (prev_fc == 255 && fc_s == 8'd0) wrap_seen = 1'b1;
      prev_fc = int'(fc_s);
    end
    chk("s_wrap_seen", int'(wrap_seen), 1);
    chk("s_wrap_next_frames", nf_cnt, 256);
    chk("s_wrap_frame_count", int'(fc_s), 1);

    // Mid-frame reset at x=3, y=2.
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      s_cycle(1'b0);
      if (x_s == 10'd3 && y_s == 10'd2) found = 1'b1;
    end
    chk("s_reach_3_2", int'(found), 1);
    s_cycle(1'b1);
    s_cycle(1'b0);
    chk("s_mid_rst_x", int'(x_s), 0);
    chk("s_mid_rst_y", int'(y_s), 0);
    chk("s_mid_rst_frame_count", int'(fc_s), 0);
    n = 0;
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      s_cycle(1'b0);
      n++;
      if (nf_s) found = 1'b1;
    end
    chk("s_mid_rst_nf_seen", int'(found), 1);
    chk("s_mid_rst_nf_delay", n, 56);
    chk("s_queue_left", sb.size(), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Raster timing source for the pattern pipeline, producing the pixel coordinates, sync pulses, blanking flag and frame strobe.
- Pattern generators consume its outputs: x low bits, y bit 5, next_frame.
- Generators return 6-bit RGB. The top level masks that RGB with display_on.
- One pixel per clk (25.175/25 MHz pixel clock). Default geometry is 640x480@60.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_ACTIVE_LOW, 1, 1 = hsync/vsync asserted low; 0 = asserted high

Ports:
clk  input  1  pixel clock; all state on rising edge
rst  input  1  synchronous, active-high reset
x  output  10  horizontal counter, 0..H_TOTAL-1
y  output  10  vertical counter, 0..V_TOTAL-1
hsync  output  1  horizontal sync, polarity per SYNC_ACTIVE_LOW
vsync  output  1  vertical sync, polarity per SYNC_ACTIVE_LOW
display_on  output  1  high when x<H_ACTIVE and y<V_ACTIVE
line_start  output  1  one-cycle pulse when x==0
next_frame  output  1  one-cycle pulse at start of vertical blanking
frame_count  output  8  frames completed, wraps 255->0

Behaviour:
- Reset and clocking:
  - One clock; reset is synchronous and active-high.
  - rst is sampled only on a clk rising edge.
  - rst has priority over counting, including mid-line or mid-frame: the next edge forces x=0, y=0, frame_count=0.
- Derived totals: H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL likewise (525). Both must fit in 10 bits.
- Counting, per clk when not in reset:
  - x increments by 1.
  - When x==H_TOTAL-1: x wraps to 0 and y increments.
  - When additionally y==V_TOTAL-1: y wraps to 0.
  - x and y never exceed H_TOTAL-1 / V_TOTAL-1.
- Output decode:
  - hsync, vsync, display_on, line_start and next_frame are pure functions of the current x and y registers. They have zero latency relative to x/y, so a pixel's RGB computed from x/y lines up with its sync and blank.
- hsync asserted when H_ACTIVE+H_FRONT <= x < H_ACTIVE+H_FRONT+H_SYNC (656..751 default).
- vsync asserted when V_ACTIVE+V_FRONT <= y < V_ACTIVE+V_FRONT+V_SYNC (490..491 default). It asserts and deasserts at x==0 boundaries.
- Polarity: the asserted level is 0 when SYNC_ACTIVE_LOW=1, otherwise 1.
- line_start: high iff x==0, on every line including blanking lines.
- next_frame:
  - High iff x==0 and y==V_ACTIVE: exactly one cycle per frame.
  - It falls in blanking, so pattern state (e.g. animation accumulators) changes only while display_on=0.
- frame_count:
  - Increments on the edge that ends the x==H_TOTAL-1, y==V_TOTAL-1 cycle.
  - 8-bit unsigned, wraps 255->0.
- Reset values, observed in the cycle after a reset edge:
  - x=0, y=0, frame_count=0.
  - display_on=1, line_start=1.
  - hsync and vsync at their deasserted level (1 when SYNC_ACTIVE_LOW=1).
  - next_frame=0.
- Boundary cases:
  - display_on drops at x==H_ACTIVE (640) and returns at x==0 of line 0.
  - Lines 480..524 have display_on=0 for all x.
  - First cycle after the end-of-frame edge: x=0, y=0 and frame_count+1 appear together.

Test Plan:
- Reset check: hold rst 3 cycles at arbitrary counter state (x=700, y=300), then release -> x=0, y=0, frame_count=0, display_on=1, hsync=1, vsync=1, next_frame=0, line_start=1.
- Line timing: run one line from reset, default params -> x=639 with display_on=1; x=640 with display_on=0; hsync=0 exactly for x=656..751 (96 cycles); after x=799, x=0 and y=1.
- Frame timing: run 800*525 cycles ->
  - vsync=0 for exactly 1600 cycles (y=490..491).
  - next_frame high for exactly 1 cycle, at x=0, y=480.
  - line_start high 525 times.
  - frame_count goes 0->1 on the cycle where x=0, y=0.
- frame_count wrap: run 256 frames -> frame_count steps 255->0; next_frame counted 256 times.
- Mid-frame reset: assert rst for 1 cycle at x=123, y=456 -> next cycle x=0, y=0, frame_count=0; a further 800*480 cycles elapse before the next next_frame.
- Polarity: SYNC_ACTIVE_LOW=0, small params (H 8/2/2/2, V 4/1/1/1) -> hsync=1 only at x=10..11, vsync=1 only at y=5; H_TOTAL=14, V_TOTAL=7 wrap points observed.
